// File: rtl/uart_pkg.sv
// uart_pkg: shared types and timing helpers for the UART transmitter and
// receiver.
//   tx_state_t    - transmit FSM states
//   rx_state_t    - receive FSM states
//   clks_per_bit  - system clocks per serial bit (integer division)
//   half_bit      - clocks in half a bit period, used for mid-bit sampling
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_if.sv
// uart_if: signal bundle for uart_top, plus the two internal bit-clock
// registers (uclktx, uclkrx) so a bench can observe TX ticks and RX sample
// points without poking into the hierarchy itself.
interface uart_if;
  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] dintx;
  logic       newd;
  logic       tx;
  logic [7:0] doutrx;
  logic       donetx;
  logic       donerx;
  logic       uclktx;
  logic       uclkrx;
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
//   clk, rst (async, active-low)
//   rx     - serial line, idle high; treated as already in the clk domain
//            (loopback or pre-synchronised pin)
//   doutrx - last byte whose stop bit read 1
//   donerx - high for CLKS_PER_BIT clocks after a good frame
// Start bit is re-checked at mid-bit to reject glitches; data and stop are
// sampled one bit period apart from there. uclk toggles at each sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] doutrx,
  output logic       donerx
);

  localparam int CLKS_PER_BIT = clks_per_bit(clk_freq, baud_rate);
  localparam int HALF_BIT     = half_bit(CLKS_PER_BIT);
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);

  rx_state_t     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [CW-1:0] done_cnt, done_cnt_d;
  logic [7:0]    shift, shift_d;
  logic [7:0]    dout_d;
  logic [2:0]    idx, idx_d;
  logic          done_d;
  logic          uclk, uclk_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      done_cnt <= '0;
      shift    <= '0;
      idx      <= '0;
      doutrx   <= '0;
      donerx   <= 1'b0;
      uclk     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      done_cnt <= done_cnt_d;
      shift    <= shift_d;
      idx      <= idx_d;
      doutrx   <= dout_d;
      donerx   <= done_d;
      uclk     <= uclk_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    done_cnt_d = done_cnt;
    shift_d    = shift;
    idx_d      = idx;
    dout_d     = doutrx;
    done_d     = donerx;
    uclk_d     = uclk;

    // donerx window runs independently so a new frame can start under it.
    if (donerx) begin
      if (done_cnt == CW'(CLKS_PER_BIT - 1)) done_d = 1'b0;
      else done_cnt_d = done_cnt + CW'(1);
    end

    case (state)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = RX_START;
      end
      RX_START: begin
        if (cnt == CW'(HALF_BIT - 1)) begin
          cnt_d   = '0;
          uclk_d  = ~uclk;
          idx_d   = 3'd0;
          state_d = rx ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          uclk_d  = ~uclk;
          shift_d = {rx, shift[7:1]};
          idx_d   = idx + 3'd1;
          if (idx == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          uclk_d  = ~uclk;
          state_d = RX_IDLE;
          // A low stop bit is a framing error: keep the previous byte.
          if (rx) begin
            dout_d     = shift;
            done_d     = 1'b1;
            done_cnt_d = '0;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter.
//   clk, rst (async, active-low)
//   newd   - level request, only looked at on a bit tick while idle
//   dintx  - byte to send, latched when the request is accepted
//   tx     - serial line, idle high
//   donetx - high for exactly one bit period after the stop bit
// A free-running divider toggles uclk every HALF_BIT clocks; the cycle in
// which uclk rises is the bit tick. uclk is plain data, never a clock.
module uart_tx
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newd,
  input  logic [7:0] dintx,
  output logic       tx,
  output logic       donetx
);

  localparam int CLKS_PER_BIT = clks_per_bit(clk_freq, baud_rate);
  localparam int HALF_BIT     = half_bit(CLKS_PER_BIT);
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);

  logic [CW-1:0] div_cnt;
  logic          uclk;
  logic          tick;

  tx_state_t     state, state_d;
  logic [7:0]    data, data_d;
  logic [2:0]    idx, idx_d;
  logic          tx_d, done_d;

  // Tick is the cycle whose edge makes uclk go 0 -> 1.
  assign tick = (div_cnt == CW'(HALF_BIT - 1)) && !uclk;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      uclk    <= 1'b0;
    end else if (div_cnt == CW'(HALF_BIT - 1)) begin
      div_cnt <= '0;
      uclk    <= ~uclk;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= TX_IDLE;
      data   <= '0;
      idx    <= '0;
      tx     <= 1'b1;
      donetx <= 1'b0;
    end else begin
      state  <= state_d;
      data   <= data_d;
      idx    <= idx_d;
      tx     <= tx_d;
      donetx <= done_d;
    end
  end

  // NOTE: every output of this block is given a default first; a path that
  // left one unassigned would infer a latch.
  always_comb begin
    state_d = state;
    data_d  = data;
    idx_d   = idx;
    tx_d    = tx;
    done_d  = donetx;
    if (tick) begin
      case (state)
        TX_IDLE: begin
          if (newd) begin
            data_d  = dintx;
            tx_d    = 1'b0;
            state_d = TX_START;
          end else begin
            tx_d = 1'b1;
          end
        end
        TX_START: begin
          tx_d    = data[0];
          idx_d   = 3'd0;
          state_d = TX_DATA;
        end
        TX_DATA: begin
          if (idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            idx_d = idx + 3'd1;
            tx_d  = data[idx_d];
          end
        end
        TX_STOP: begin
          done_d  = 1'b1;
          state_d = TX_DONE;
        end
        TX_DONE: begin
          done_d  = 1'b0;
          state_d = TX_IDLE;
        end
        default: state_d = TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_top.sv
// uart_top: independent 8N1 transmitter and receiver on one clock.
//   clk, rst (async, active-low)
//   rx     - serial input, idle high
//   dintx  - byte to transmit; newd - transmit request (level)
//   tx     - serial output, idle high
//   doutrx - last good received byte
//   donetx - transmit-complete flag; donerx - receive-complete flag
module uart_top #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [7:0] dintx,
  input  logic       newd,
  output logic       tx,
  output logic [7:0] doutrx,
  output logic       donetx,
  output logic       donerx
);

  uart_tx #(
    .clk_freq (clk_freq),
    .baud_rate(baud_rate)
  ) utx (
    .clk   (clk),
    .rst   (rst),
    .newd  (newd),
    .dintx (dintx),
    .tx    (tx),
    .donetx(donetx)
  );

  uart_rx #(
    .clk_freq (clk_freq),
    .baud_rate(baud_rate)
  ) rtx (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .doutrx(doutrx),
    .donerx(donerx)
  );

endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: directed bench for uart_top at default parameters
// (104 clocks per bit). rx is either looped back from tx or driven directly.
module tb_uart_top;

  uart_if vif ();

  logic loopback = 1'b1;
  logic rx_drv   = 1'b1;

  assign vif.rx     = loopback ? vif.tx : rx_drv;
  assign vif.uclktx = dut.utx.uclk;
  assign vif.uclkrx = dut.rtx.uclk;

  uart_top dut (
    .clk   (vif.clk),
    .rst   (vif.rst),
    .rx    (vif.rx),
    .dintx (vif.dintx),
    .newd  (vif.newd),
    .tx    (vif.tx),
    .doutrx(vif.doutrx),
    .donetx(vif.donetx),
    .donerx(vif.donerx)
  );

  initial vif.clk = 1'b0;
  always #5 vif.clk = ~vif.clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle counter and flag monitors (pulse counts, last donerx width).
  int   cyc      = 0;
  int   n_donetx = 0;
  int   n_donerx = 0;
  int   rx_hi    = 0;
  int   rx_width = 0;
  logic p_donetx = 1'b0;
  logic p_donerx = 1'b0;

  always @(posedge vif.clk) cyc <= cyc + 1;

  always @(negedge vif.clk) begin
    if (vif.donetx && !p_donetx) n_donetx <= n_donetx + 1;
    if (vif.donerx && !p_donerx) n_donerx <= n_donerx + 1;
    if (vif.donerx) rx_hi <= rx_hi + 1;
    else if (p_donerx) begin
      rx_width <= rx_hi;
      rx_hi    <= 0;
    end
    p_donetx <= vif.donetx;
    p_donerx <= vif.donerx;
  end

  // Bounded wait at negedges: which = 0 tx, 1 donetx, 2 donerx.
  task automatic wait_for(input string tag, input int which, input logic level, input int max);
    logic seen;
    logic s;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge vif.clk);
      case (which)
        0:       s = vif.tx;
        1:       s = vif.donetx;
        default: s = vif.donerx;
      endcase
      if (s === level) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  int t0;

  task automatic start_frame(input logic [7:0] b);
    vif.dintx = b;
    vif.newd  = 1'b1;
    wait_for("accept", 0, 1'b0, 300);
    t0 = cyc;
    vif.newd = 1'b0;
  endtask

  task automatic wait_done();
    wait_for("donetx_rise", 1, 1'b1, 1500);
    wait_for("donetx_fall", 1, 1'b0, 300);
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = fr[k];
      repeat (104) @(negedge vif.clk);
    end
    rx_drv = 1'b1;
  endtask

  logic [9:0] a5_frame;
  logic [7:0] bytes [5];
  int         ntx0, nrx0;

  initial begin
    vif.rst   = 1'b0;
    vif.dintx = 8'h00;
    vif.newd  = 1'b0;

    // Reset state
    repeat (3) @(negedge vif.clk);
    check("rst_tx", vif.tx, 1'b1);
    check("rst_donetx", vif.donetx, 1'b0);
    check("rst_donerx", vif.donerx, 1'b0);
    check("rst_doutrx", vif.doutrx, 8'h00);
    check("rst_uclktx", vif.uclktx, 1'b0);
    check("rst_uclkrx", vif.uclkrx, 1'b0);
    vif.rst = 1'b1;

    // Loopback A5: bit pattern, donetx latency, received byte
    ntx0 = n_donetx;
    nrx0 = n_donerx;
    start_frame(8'hA5);
    a5_frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 52 : 104) @(negedge vif.clk);
      check($sformatf("a5_bit%0d", k), vif.tx, a5_frame[k]);
    end
    wait_for("a5_donetx", 1, 1'b1, 300);
    check("a5_done_latency", cyc - t0, 1040);
    wait_for("a5_donetx_fall", 1, 1'b0, 300);
    check("a5_doutrx", vif.doutrx, 8'hA5);
    check("a5_donerx_cnt", n_donerx - nrx0, 1);

    // Five loopback bytes including both extremes
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'($urandom_range(255));
    bytes[3] = 8'($urandom_range(255));
    bytes[4] = 8'($urandom_range(255));
    ntx0 = n_donetx;
    nrx0 = n_donerx;
    for (int i = 0; i < 5; i++) begin
      start_frame(bytes[i]);
      wait_done();
      check($sformatf("rand%0d_doutrx", i), vif.doutrx, bytes[i]);
    end
    check("rand_donetx_cnt", n_donetx - ntx0, 5);
    check("rand_donerx_cnt", n_donerx - nrx0, 5);

    // Mid-frame dintx change and newd pulse are ignored
    ntx0 = n_donetx;
    nrx0 = n_donerx;
    start_frame(8'h5A);
    repeat (300) @(negedge vif.clk);
    vif.dintx = 8'hC3;
    vif.newd  = 1'b1;
    repeat (30) @(negedge vif.clk);
    vif.newd = 1'b0;
    wait_done();
    repeat (1500) @(negedge vif.clk);
    check("mid_doutrx", vif.doutrx, 8'h5A);
    check("mid_donetx_cnt", n_donetx - ntx0, 1);
    check("mid_donerx_cnt", n_donerx - nrx0, 1);
    check("mid_tx_idle", vif.tx, 1'b1);

    // 20-cycle glitch on rx is rejected
    loopback = 1'b0;
    nrx0 = n_donerx;
    rx_drv = 1'b0;
    repeat (20) @(negedge vif.clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge vif.clk);
    check("glitch_donerx_cnt", n_donerx - nrx0, 0);
    check("glitch_doutrx", vif.doutrx, 8'h5A);

    // Framing error: stop bit low
    drive_rx_frame(8'h96, 1'b0);
    repeat (300) @(negedge vif.clk);
    check("frame_err_donerx_cnt", n_donerx - nrx0, 0);
    check("frame_err_doutrx", vif.doutrx, 8'h5A);

    // Directly driven good frame; donerx width is one bit period
    drive_rx_frame(8'h96, 1'b1);
    repeat (300) @(negedge vif.clk);
    check("drv_doutrx", vif.doutrx, 8'h96);
    check("drv_donerx_cnt", n_donerx - nrx0, 1);
    check("drv_donerx_width", rx_width, 104);

    // Reset in the middle of DATA, then a clean 3C frame
    loopback = 1'b1;
    start_frame(8'hE7);
    repeat (400) @(negedge vif.clk);
    vif.rst = 1'b0;
    #1;
    check("midrst_tx", vif.tx, 1'b1);
    check("midrst_donetx", vif.donetx, 1'b0);
    check("midrst_donerx", vif.donerx, 1'b0);
    check("midrst_doutrx", vif.doutrx, 8'h00);
    repeat (5) @(negedge vif.clk);
    vif.rst = 1'b1;
    ntx0 = n_donetx;
    nrx0 = n_donerx;
    start_frame(8'h3C);
    wait_done();
    repeat (50) @(negedge vif.clk);
    check("post_rst_doutrx", vif.doutrx, 8'h3C);
    check("post_rst_donetx_cnt", n_donetx - ntx0, 1);
    check("post_rst_donerx_cnt", n_donerx - nrx0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
